// File: rtl/cpu_pkg.sv
// Shared CPU constants: MUL opcode, instruction field positions and the
// sequencer state encoding.
package cpu_pkg;

  localparam logic [6:0] OP_MUL = 7'b0101000;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 25;
  localparam int RD_HI  = 24;
  localparam int RD_LO  = 21;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'(S_IDLE),
    ST_RUN  = 2'(S_RUN),
    ST_DONE = 2'(S_DONE)
  } state_e;

  function automatic logic is_opcode(input logic [31:0] instr, input logic [6:0] opc);
    return instr[OPC_HI:OPC_LO] == opc;
  endfunction

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-and-add multiplier datapath: one partial product per step, with the
// accumulator's next value and a "remaining multiplier is zero" look-ahead.
module mul_shift_add_dp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH-1:0] acc_next_o,
  output logic             mplier_next_zero_o
);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] mplier_d;

  // Sum wraps at WIDTH bits, so the result is the low half of the product.
  assign acc_d    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign mplier_d = mplier_q >> 1;

  assign acc_next_o         = acc_d;
  assign mplier_next_zero_o = (mplier_d == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else if (load_i) begin
      mcand_q  <= mcand_i;
      mplier_q <= mplier_i;
      acc_q    <= '0;
    end else if (step_i) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

endmodule

// File: rtl/mul_ucode_seq.sv
// MUL microcode sequencer: freezes fetch on a MUL, iterates the shift-and-add
// datapath, writes the low product back and releases fetch.
module mul_ucode_seq
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RAW        = 4,
  parameter logic [6:0]  MUL_OPCODE = OP_MUL,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_in,
  input  logic             instr_valid,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             flush,
  output logic             mul_trigger,
  output logic             mul_release,
  output logic             busy,
  output logic             wb_en,
  output logic [RAW-1:0]   wb_addr,
  output logic [WIDTH-1:0] wb_data
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic [RAW-1:0]   rd_q;
  logic             mul_release_q;
  logic             wb_en_q;
  logic [RAW-1:0]   wb_addr_q;
  logic [WIDTH-1:0] wb_data_q;

  logic             dp_step;
  logic [WIDTH-1:0] acc_next;
  logic             mplier_next_zero;
  logic             run_done;
  logic             unused_instr;

  assign unused_instr = ^instr_in;

  assign mul_trigger = ~rst & (state_q == ST_IDLE) & instr_valid
                     & is_opcode(instr_in, MUL_OPCODE) & ~flush;

  assign dp_step  = (state_q == ST_RUN) & ~flush;
  assign count_d  = count_q - CW'(1);
  assign run_done = (count_d == '0) || (EARLY_EXIT && mplier_next_zero);

  mul_shift_add_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk                (clk),
    .rst                (rst),
    .load_i             (mul_trigger),
    .step_i             (dp_step),
    .mcand_i            (op_a),
    .mplier_i           (op_b),
    .acc_next_o         (acc_next),
    .mplier_next_zero_o (mplier_next_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      count_q       <= '0;
      rd_q          <= '0;
      mul_release_q <= 1'b0;
      wb_en_q       <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
    end else begin
      mul_release_q <= 1'b0;
      wb_en_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mul_trigger) begin
            rd_q    <= instr_in[RD_LO +: RAW];
            count_q <= CW'(WIDTH);
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          // An abort still releases fetch so it can leave its microcode state.
          if (flush) begin
            state_q       <= ST_IDLE;
            mul_release_q <= 1'b1;
          end else begin
            count_q <= count_d;
            if (run_done) begin
              state_q       <= ST_DONE;
              mul_release_q <= 1'b1;
              wb_en_q       <= 1'b1;
              wb_addr_q     <= rd_q;
              wb_data_q     <= acc_next;
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign mul_release = mul_release_q;
  assign wb_en       = wb_en_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;

endmodule

// File: tb/tb_mul_ucode_seq.sv
// Bench for mul_ucode_seq: vector table plus hand-written flush, reset and
// back-to-back sequences; writebacks are checked against a scoreboard queue.
module tb_mul_ucode_seq;

  localparam logic [6:0] OPM = 7'b0101000;
  localparam logic [6:0] OPN = 7'b0101001;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        mul_trigger;
  logic        mul_release;
  logic        busy;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  addr;
  } wb_t;
  wb_t sb_q[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rd;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  mul_ucode_seq #(
    .WIDTH      (32),
    .RAW        (4),
    .MUL_OPCODE (7'b0101000),
    .EARLY_EXIT (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .op_a        (op_a),
    .op_b        (op_b),
    .flush       (flush),
    .mul_trigger (mul_trigger),
    .mul_release (mul_release),
    .busy        (busy),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [3:0] rd);
    return {opc, rd, 21'h0};
  endfunction

  // DONE lands 1 + max(1, msb_index(b)+1) cycles after the trigger.
  function automatic int exp_lat(input logic [31:0] b);
    int m = 0;
    for (int i = 0; i < 32; i++) if (b[i]) m = i + 1;
    return 1 + ((m < 1) ? 1 : m);
  endfunction

  // Writeback monitor: every wb_en must match the oldest expected result.
  always @(negedge clk) begin
    if (wb_en) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL wb_unexpected: got wb_en=1 addr=%h data=%h expected no writeback", wb_addr, wb_data);
      end else begin
        wb_t e;
        e = sb_q.pop_front();
        check("wb_data", wb_data, e.data);
        check("wb_addr", 32'(wb_addr), 32'(e.addr));
        check("wb_release", 32'(mul_release), 32'd1);
        $display("wb: addr=%0d data=%h (expected addr=%0d data=%h)", wb_addr, wb_data, e.addr, e.data);
      end
    end
    if (mul_trigger && busy) check("trig_while_busy", 32'(mul_trigger), 32'd0);
  end

  task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] rd, input logic [31:0] exp, input int lat);
    int  n;
    bit  seen;
    instr_in    = mk(OPM, rd);
    instr_valid = 1'b1;
    op_a        = a;
    op_b        = b;
    @(negedge clk);
    check({name, ":trig"}, 32'(mul_trigger), 32'd1);
    sb_q.push_back('{data: exp, addr: rd});
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr_in    = mk(OPN, 4'd0);
    op_a        = $urandom;
    op_b        = $urandom;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 80) begin
      @(negedge clk);
      n++;
      if (wb_en) seen = 1'b1;
      else check({name, ":busy_run"}, 32'(busy), 32'd1);
    end
    check({name, ":latency"}, 32'(n), 32'(lat));
    $display("mul %s: a=%h b=%h rd=%0d latency=%0d (expected %0d)", name, a, b, rd, n, lat);
    @(posedge clk); #1;
    @(negedge clk);
    check({name, ":busy_after"}, 32'(busy), 32'd0);
    check({name, ":rel_after"}, 32'(mul_release), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{a: 32'd6,          b: 32'd7,          rd: 4'd3,  exp: 32'd42,         lat: 4};
    vecs[1] = '{a: 32'hFFFFFFFF,   b: 32'd0,          rd: 4'd5,  exp: 32'd0,          lat: 2};
    vecs[2] = '{a: 32'h80000000,   b: 32'd3,          rd: 4'd7,  exp: 32'h80000000,   lat: 3};
    vecs[3] = '{a: 32'd3,          b: 32'hFFFFFFFF,   rd: 4'd9,  exp: 32'hFFFFFFFD,   lat: 33};
    vecs[4] = '{a: 32'hFFFFFFFF,   b: 32'hFFFFFFFF,   rd: 4'd15, exp: 32'd1,          lat: 33};
    vecs[5] = '{a: 32'h12345678,   b: 32'h10,         rd: 4'd1,  exp: 32'h23456780,   lat: 6};
    vecs[6] = '{a: 32'h3E8,        b: 32'h3E8,        rd: 4'd11, exp: 32'h000F4240,   lat: 11};

    // Reset state, with a valid MUL presented while rst is high.
    rst         = 1'b1;
    flush       = 1'b0;
    instr_in    = mk(OPM, 4'd4);
    instr_valid = 1'b1;
    op_a        = 32'd9;
    op_b        = 32'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst:trig", 32'(mul_trigger), 32'd0);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:wb_en", 32'(wb_en), 32'd0);
    check("rst:release", 32'(mul_release), 32'd0);
    check("rst:wb_addr", 32'(wb_addr), 32'd0);
    check("rst:wb_data", wb_data, 32'd0);
    @(posedge clk); #1;
    rst         = 1'b0;
    instr_valid = 1'b0;
    @(posedge clk); #1;

    // Random operands against the bench's own product/latency model.
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      run_vec($sformatf("rnd%0d", i), a, b, 4'(i + 2), a * b, exp_lat(b));
    end

    for (int i = 0; i < 7; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp, vecs[i].lat);

    // Flush in IDLE suppresses the trigger.
    instr_in    = mk(OPM, 4'd8);
    instr_valid = 1'b1;
    flush       = 1'b1;
    @(negedge clk);
    check("flush_idle:trig", 32'(mul_trigger), 32'd0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    flush       = 1'b0;
    @(negedge clk);
    check("flush_idle:busy", 32'(busy), 32'd0);
    @(posedge clk); #1;

    // Flush mid-RUN: back to IDLE with a release pulse and no writeback.
    instr_in    = mk(OPM, 4'd6);
    instr_valid = 1'b1;
    op_a        = 32'd5;
    op_b        = 32'hFF;
    @(negedge clk);
    check("flush_run:trig", 32'(mul_trigger), 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    check("flush_run:busy_t2", 32'(busy), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_run:busy_t3", 32'(busy), 32'd0);
    check("flush_run:release_t3", 32'(mul_release), 32'd1);
    check("flush_run:wb_en_t3", 32'(wb_en), 32'd0);
    @(negedge clk);
    check("flush_run:release_t4", 32'(mul_release), 32'd0);
    $display("flush mid-run: busy=%0d release pulse observed", busy);
    repeat (12) @(posedge clk);
    #1;

    // Reset mid-RUN: outputs clear, no release, next MUL triggers normally.
    instr_in    = mk(OPM, 4'd6);
    instr_valid = 1'b1;
    op_a        = 32'd7;
    op_b        = 32'hFF;
    @(negedge clk);
    check("rst_run:trig", 32'(mul_trigger), 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    rst         = 1'b1;
    instr_valid = 1'b1;
    @(negedge clk);
    check("rst_run:trig_in_rst", 32'(mul_trigger), 32'd0);
    @(posedge clk); #1;
    rst         = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    check("rst_run:busy", 32'(busy), 32'd0);
    check("rst_run:release", 32'(mul_release), 32'd0);
    check("rst_run:wb_en", 32'(wb_en), 32'd0);
    check("rst_run:wb_addr", 32'(wb_addr), 32'd0);
    check("rst_run:wb_data", wb_data, 32'd0);
    @(posedge clk); #1;
    run_vec("post_rst", 32'd2, 32'd9, 4'd4, 32'd18, 5);

    // Back-to-back: 5x5 then 3x4 held on the bus; second trigger at DONE+1.
    instr_in    = mk(OPM, 4'd1);
    instr_valid = 1'b1;
    op_a        = 32'd5;
    op_b        = 32'd5;
    @(negedge clk);
    check("b2b:trig0", 32'(mul_trigger), 32'd1);
    sb_q.push_back('{data: 32'd25, addr: 4'd1});
    sb_q.push_back('{data: 32'd12, addr: 4'd2});
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      instr_in = (k == 1) ? mk(OPN, 4'd2) : mk(OPM, 4'd2);
      op_a     = 32'd3;
      op_b     = 32'd4;
      @(negedge clk);
      check($sformatf("b2b:trig%0d", k), 32'(mul_trigger), 32'(k == 5));
    end
    check("b2b:busy_at_retrigger", 32'(busy), 32'd0);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr_in    = mk(OPN, 4'd0);
    begin
      int n = 0;
      while (sb_q.size() > 0 && n < 80) begin
        @(negedge clk);
        n++;
      end
    end
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
